// File: rtl/el2_ifu_fetch_buf_if.sv
// Fetch-buffer bus: F-stage packet write side, decode issue side and buffer status.
// The master drives fetch/decode inputs; the slave is the fetch buffer itself.
interface el2_ifu_fetch_buf_if;
  logic        ifc_fetch_req_f;
  logic        ic_hit_f;
  logic [31:1] ifc_fetch_addr_f;
  logic [63:0] ic_data_f;
  logic        exu_flush_final;
  logic        dec_ib_ready;
  logic        ifu_i0_valid;
  logic [31:0] ifu_i0_instr;
  logic [31:1] ifu_i0_pc;
  logic        ifu_i0_pc4;
  logic        ifu_fb_consume1;
  logic        ifu_fb_consume2;
  logic [2:0]  fb_count;
  logic        fb_overflow;

  modport master (
    output ifc_fetch_req_f, ic_hit_f, ifc_fetch_addr_f, ic_data_f, exu_flush_final, dec_ib_ready,
    input  ifu_i0_valid, ifu_i0_instr, ifu_i0_pc, ifu_i0_pc4, ifu_fb_consume1, ifu_fb_consume2,
           fb_count, fb_overflow
  );

  modport slave (
    input  ifc_fetch_req_f, ic_hit_f, ifc_fetch_addr_f, ic_data_f, exu_flush_final, dec_ib_ready,
    output ifu_i0_valid, ifu_i0_instr, ifu_i0_pc, ifu_i0_pc4, ifu_fb_consume1, ifu_fb_consume2,
           fb_count, fb_overflow
  );
endinterface

// File: rtl/el2_ifu_fetch_buf.sv
// 4-entry circular fetch buffer with a halfword aligner that issues one 16/32-bit
// instruction per cycle and reports freed entries back to fetch control.
module el2_ifu_fetch_buf #(
  parameter int FB_DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  el2_ifu_fetch_buf_if.slave fb
);

  logic [63:0] data_q [FB_DEPTH];
  logic [63:0] data_d [FB_DEPTH];
  logic [31:3] pc_q   [FB_DEPTH];
  logic [31:3] pc_d   [FB_DEPTH];
  logic [3:0]  hwv_q  [FB_DEPTH];
  logic [3:0]  hwv_d  [FB_DEPTH];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        overflow_q, overflow_d;

  logic [1:0]  head, nxt;
  logic [3:0]  head_hwv, nxt_hwv;
  logic [63:0] head_data, nxt_data;
  logic [1:0]  h0_idx, up_idx, n0_idx;
  logic        up_found, n0_found, nxt_occ;
  logic [15:0] lo_hw, hi_hw;
  logic        is32, hi_avail, valid_raw, valid, accept;
  logic [3:0]  head_hwv_new, nxt_hwv_new;
  logic        free_head, free_nxt;
  logic [1:0]  freed;
  logic        wr_req, drop, do_write;
  logic [3:0]  wr_mask;

  // Aligner: the upper half of a 32-bit instruction comes from the head entry if it
  // has a later valid halfword, otherwise from the first valid halfword of entry+1.
  always_comb begin
    head      = rd_ptr_q;
    nxt       = rd_ptr_q + 2'd1;
    head_hwv  = hwv_q[head];
    nxt_hwv   = hwv_q[nxt];
    head_data = data_q[head];
    nxt_data  = data_q[nxt];
    nxt_occ   = (count_q >= 3'd2);
    h0_idx    = '0;
    up_idx    = '0;
    up_found  = 1'b0;
    n0_idx    = '0;
    n0_found  = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (head_hwv[k]) h0_idx = k[1:0];
    end
    for (int k = 3; k >= 0; k--) begin
      if (head_hwv[k] && (k[1:0] > h0_idx)) begin
        up_idx   = k[1:0];
        up_found = 1'b1;
      end
    end
    for (int k = 3; k >= 0; k--) begin
      if (nxt_hwv[k]) begin
        n0_idx   = k[1:0];
        n0_found = nxt_occ;
      end
    end
    lo_hw     = head_data[{h0_idx, 4'b0000} +: 16];
    hi_hw     = up_found ? head_data[{up_idx, 4'b0000} +: 16] : nxt_data[{n0_idx, 4'b0000} +: 16];
    is32      = (lo_hw[1:0] == 2'b11);
    hi_avail  = up_found | n0_found;
    valid_raw = (count_q != 3'd0) & (~is32 | hi_avail);
    valid     = valid_raw & ~fb.exu_flush_final;
    accept    = valid & fb.dec_ib_ready;

    head_hwv_new = head_hwv & ~(4'b0001 << h0_idx);
    if (is32 && up_found) head_hwv_new = head_hwv_new & ~(4'b0001 << up_idx);
    nxt_hwv_new = nxt_hwv;
    if (is32 && !up_found) nxt_hwv_new = nxt_hwv & ~(4'b0001 << n0_idx);
    free_head = accept & (head_hwv_new == 4'b0000);
    free_nxt  = accept & is32 & ~up_found & (nxt_hwv_new == 4'b0000);
    freed     = {1'b0, free_head} + {1'b0, free_nxt};
  end

  // A full buffer can still take a write when the same-cycle accept frees the head slot.
  always_comb begin
    data_d   = data_q;
    pc_d     = pc_q;
    hwv_d    = hwv_q;
    wr_mask  = '0;
    for (int k = 0; k < 4; k++) begin
      wr_mask[k] = (k[1:0] >= fb.ifc_fetch_addr_f[2:1]);
    end
    wr_req   = fb.ifc_fetch_req_f & fb.ic_hit_f & ~fb.exu_flush_final;
    drop     = wr_req & (count_q == 3'd4) & (freed == 2'd0);
    do_write = wr_req & ~drop;

    if (accept) begin
      hwv_d[head] = head_hwv_new;
      hwv_d[nxt]  = nxt_hwv_new;
    end
    if (do_write) begin
      data_d[wr_ptr_q] = fb.ic_data_f;
      pc_d[wr_ptr_q]   = fb.ifc_fetch_addr_f[31:3];
      hwv_d[wr_ptr_q]  = wr_mask;
    end
    wr_ptr_d   = wr_ptr_q + {1'b0, do_write};
    rd_ptr_d   = rd_ptr_q + freed;
    count_d    = count_q + {2'b00, do_write} - {1'b0, freed};
    overflow_d = overflow_q | drop;

    if (fb.exu_flush_final) begin
      hwv_d    = '{default: '0};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '{default: '0};
      pc_q       <= '{default: '0};
      hwv_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      pc_q       <= pc_d;
      hwv_q      <= hwv_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Instruction fields read as zero whenever nothing is being presented.
  assign fb.ifu_i0_valid    = valid;
  assign fb.ifu_i0_instr    = !valid ? 32'h0 : (is32 ? {hi_hw, lo_hw} : {16'h0000, lo_hw});
  assign fb.ifu_i0_pc       = valid ? {pc_q[head], h0_idx} : 31'h0;
  assign fb.ifu_i0_pc4      = valid & is32;
  assign fb.ifu_fb_consume1 = (freed == 2'd1);
  assign fb.ifu_fb_consume2 = (freed == 2'd2);
  assign fb.fb_count        = count_q;
  assign fb.fb_overflow     = overflow_q;

endmodule
